sseg_scan_ctrl: RTL
===================

Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of NDIG common-enable seven-segment digits that share one 4-bit-to-segment decoder.
- Presents one nibble per digit slot on bit3..bit0 for the decoder and drives one-hot digit enables.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).

Parameters:
NDIG, 4, number of digits scanned; legal 2..8.
SHOW_CYCLES, 50000, clk cycles each digit is lit; legal >= 1.
BLANK_CYCLES, 500, clk cycles all enables are low before each digit; legal >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = scanning runs; 0 = freeze counters and force an = 0.
load  input  1  single-cycle request to update the displayed value.
value  input  4*NDIG  new value; digit k = value[4k+3:4k], digit 0 rightmost.
bit3, bit2, bit1, bit0  output  1 each  nibble of the active digit, to the decoder inputs.
an  output  NDIG  one-hot digit enable, active-high; all 0 during blank.
frame_done  output  1  one-cycle pulse at the end of each full frame.
load_ack  output  1  one-cycle pulse when a pending value is committed to the display.

Behaviour:
- Registers: state {BLANK, SHOW}, cycle counter wide enough for max(SHOW_CYCLES, BLANK_CYCLES)-1, digit index idx (0..NDIG-1), shadow[4*NDIG], pend_val[4*NDIG], pend flag.
- All outputs are registered.
- Reset (async, any time, including mid-digit or mid-blank):
  - state = BLANK, counter = 0, idx = 0, shadow = 0, pend = 0, pend_val = 0.
  - an = 0, bit3..bit0 = 0, frame_done = 0, load_ack = 0.
- BLANK state:
  - an = 0; nibble outputs hold the value of the next digit, shadow[idx].
  - Counter counts 0..BLANK_CYCLES-1, then state goes to SHOW and the counter clears.
- SHOW state:
  - an[idx] = 1; bit3..bit0 = shadow[4*idx+3 : 4*idx].
  - Counter counts 0..SHOW_CYCLES-1, then state goes to BLANK, the counter clears, and idx increments.
  - idx wraps from NDIG-1 to 0.
- Frame boundary = the cycle that SHOW ends with idx = NDIG-1. On that cycle:
  - frame_done = 1 on the next cycle, for one cycle.
  - If pend = 1: shadow <= pend_val, pend <= 0, load_ack = 1 on the next cycle, for one cycle.
- Frame length = NDIG*(BLANK_CYCLES+SHOW_CYCLES) cycles.
- load = 1 on a non-boundary cycle: pend_val <= value, pend <= 1. Back-to-back loads overwrite; last one wins.
- load = 1 exactly on the boundary cycle: value bypasses to shadow directly, pend <= 0, load_ack fires next cycle. An older pending value is discarded.
- enable = 0:
  - an forced 0 combinationally-free (registered 0 next cycle).
  - state, counter and idx hold; frame_done is not generated.
  - load still captures into pend.
  - When enable returns to 1, scanning resumes from the held state/count.
- Nibble order: bit3 = MSB of the digit nibble, bit0 = LSB.
- The nibble is never changed while an is non-zero; it changes only on the BLANK entry cycle.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during SHOW, a digit k > 0 whose nibble is 0, and all of whose more-significant digits are also 0, keeps an[k] = 0 (dark); timing is unchanged. Digit 0 is always lit, so an all-zero value shows a single "0".
- Undefined: every digit is lit in its slot regardless of value.

Test Plan:
1. Reset with NDIG=4, SHOW_CYCLES=4, BLANK_CYCLES=1 -> an=0000 and bits=0 during reset. After release, the an sequence per 5-cycle slot is 0000 then 0001 (x4), 0000 then 0010, and so on. frame_done pulses every 20 cycles.
2. load=1 with value=16'h1234 mid-frame -> display stays at 0 until the boundary. load_ack then pulses once. The next frame shows nibble 4,3,2,1 while an=0001,0010,0100,1000 respectively.
3. load 16'hAAAA then 16'h5555 in the same frame -> one load_ack, and the following frame shows only 5s. load asserted exactly on the boundary cycle with 16'h0F0F -> shadow=0F0F immediately, no extra ack next frame.
4. Drop enable for 7 cycles mid-SHOW of digit 2 -> an=0000 for the whole gap. The digit resumes with its remaining SHOW cycles, and the frame is stretched by exactly 7 cycles.
5. Assert reset mid-SHOW of digit 3 with pend=1 -> all outputs return to 0, the pending value is lost, and the scan restarts at digit 0 in BLANK.
6. With LEADING_ZERO_BLANK_EN defined, value=16'h0050 -> an stays 0 in the digit 3 and 2 slots. Digits 1 (nibble 5) and 0 (nibble 0) are lit. value=0 -> only digit 0 is lit.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Walks NDIG digits through BLANK/SHOW slots, presents the active nibble on
// bit3..bit0 and a one-hot active-high enable on an. The displayed value is
// double-buffered and only changes on frame boundaries.
// Optional: `define LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
module sseg_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [4*NDIG-1:0] value,
  output logic            bit3,
  output logic            bit2,
  output logic            bit1,
  output logic            bit0,
  output logic [NDIG-1:0] an,
  output logic            frame_done,
  output logic            load_ack
);

  localparam int CMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NDIG);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   shadow_q, shadow_d;
  logic [4*NDIG-1:0]   pend_val_q, pend_val_d;
  logic                pend_q, pend_d;
  logic [3:0]          nib_q, nib_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic                fd_q, fd_d;
  logic                ack_q, ack_d;
  logic                boundary;
  logic [NDIG-1:0]     lit_mask;

  // Digits allowed to light for the value about to be displayed.
  always_comb begin
    lit_mask = '1;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int k = NDIG-1; k >= 0; k--) begin
        seen        = seen | (shadow_d[4*k +: 4] != 4'h0);
        lit_mask[k] = seen | (k == 0);
      end
    end
`endif
  end

  // Scan sequencing, double-buffer commit and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    fd_d       = 1'b0;
    ack_d      = 1'b0;

    // Last SHOW cycle of the last digit, and only when the scan actually moves.
    boundary = enable && (state_q == SHOW) && (cnt_q == CW'(SHOW_CYCLES-1)) &&
               (idx_q == IW'(NDIG-1));

    if (enable) begin
      case (state_q)
        BLANK: begin
          if (cnt_q == CW'(BLANK_CYCLES-1)) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CW'(SHOW_CYCLES-1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(NDIG-1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    if (boundary) begin
      fd_d = 1'b1;
      // A load on the boundary itself wins over any older pending value.
      if (load) begin
        shadow_d = value;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end else if (pend_q) begin
        shadow_d = pend_val_q;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  // Output values are derived from the next state so they line up with it.
  always_comb begin
    nib_d = nib_q;
    an_d  = '0;
    // Nibble only moves while dark, so the decoder never glitches a lit digit.
    if (state_d == BLANK) nib_d = shadow_d[4*idx_d +: 4];
    if (enable && (state_d == SHOW) && lit_mask[idx_d]) an_d[idx_d] = 1'b1;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      nib_q      <= 4'h0;
      an_q       <= '0;
      fd_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      nib_q      <= nib_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
      ack_q      <= ack_d;
    end
  end

  assign {bit3, bit2, bit1, bit0} = nib_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign load_ack   = ack_q;

endmodule
